// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared state encodings, flag indices and PC defaults
package pc_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   localparam int FLG_Z = 0;
   localparam int FLG_S = 1;
   localparam int FLG_C = 2;

   localparam logic [31:0] DEF_RESET_PC = 32'd0;
   localparam logic [31:0] DEF_PC_STEP  = 32'd4;

endpackage

// File: rtl/pc_sequencer_jump_unit.sv
// rtl/pc_sequencer_jump_unit.sv - next-address resolution for branch or fall-through
module jump_unit
   import pc_sequencer_pkg::*;
#(
   parameter logic [31:0] PC_STEP = DEF_PC_STEP
) (
   input  logic [31:0] PCin,
   input  logic [31:0] address,
   input  logic [31:0] res,
   input  logic        AdSel,
   input  logic        unconditional,
   input  logic [2:0]  conditional,
   input  logic [2:0]  flags,
   output logic [31:0] next_address
);

   logic taken;

   // Any selected flag that is set takes the branch; an empty mask never does.
   assign taken = unconditional
                | (conditional[FLG_Z] & flags[FLG_Z])
                | (conditional[FLG_S] & flags[FLG_S])
                | (conditional[FLG_C] & flags[FLG_C]);

   assign next_address = taken ? (AdSel ? res : address) : (PCin + PC_STEP);

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/exec controller owning PC, flags, retire count and fetch timeout
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
   parameter logic [31:0] PC_STEP   = DEF_PC_STEP,
   parameter int          FETCH_TMO = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run_en,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        ex_done,
   input  logic        br_uncond,
   input  logic [2:0]  br_cond,
   input  logic        br_adsel,
   input  logic [31:0] br_addr,
   input  logic [31:0] alu_res,
   input  logic        flag_we,
   input  logic [2:0]  flags_in,
   input  logic        halt,
   output logic [31:0] pc,
   output logic [2:0]  flags,
   output logic [31:0] retired,
   output logic        halted,
   output logic        fetch_err
);

   localparam int TW = $clog2(FETCH_TMO + 1);

   state_t        state;
   logic [TW-1:0] tmo_cnt;
   logic [31:0]   next_pc;

   assign imem_addr = pc;

   jump_unit #(.PC_STEP(PC_STEP)) u_ju (
      .PCin          (pc),
      .address       (br_addr),
      .res           (alu_res),
      .AdSel         (br_adsel),
      .unconditional (br_uncond),
      .conditional   (br_cond),
      .flags         (flags),
      .next_address  (next_pc)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         pc          <= RESET_PC;
         flags       <= 3'b000;
         retired     <= 32'd0;
         instr       <= 32'd0;
         tmo_cnt     <= '0;
         imem_req    <= 1'b0;
         instr_valid <= 1'b0;
         halted      <= 1'b0;
         fetch_err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (run_en) begin
                  state    <= ST_FETCH;
                  imem_req <= 1'b1;
                  tmo_cnt  <= '0;
               end
            end
            ST_FETCH: begin
               // An ack in the last allowed cycle still wins over the timeout.
               if (imem_ack) begin
                  instr       <= imem_rdata;
                  imem_req    <= 1'b0;
                  instr_valid <= 1'b1;
                  state       <= ST_EXEC;
               end else if (tmo_cnt == TW'(FETCH_TMO - 1)) begin
                  imem_req  <= 1'b0;
                  fetch_err <= 1'b1;
                  halted    <= 1'b1;
                  state     <= ST_HALT;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end
            ST_EXEC: begin
               instr_valid <= 1'b0;
               if (ex_done) begin
                  // Branch decision in u_ju uses the flags before this write.
                  pc      <= next_pc;
                  retired <= retired + 32'd1;
                  if (flag_we) flags <= flags_in;
                  if (halt) begin
                     halted <= 1'b1;
                     state  <= ST_HALT;
                  end else begin
                     imem_req <= 1'b1;
                     tmo_cnt  <= '0;
                     state    <= ST_FETCH;
                  end
               end
            end
            default: begin
               imem_req <= 1'b0;
               halted   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer
module tb_pc_sequencer;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        run_en = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic [31:0] instr;
   logic        instr_valid;
   logic        ex_done = 1'b0;
   logic        br_uncond = 1'b0;
   logic [2:0]  br_cond = 3'b000;
   logic        br_adsel = 1'b0;
   logic [31:0] br_addr = 32'd0;
   logic [31:0] alu_res = 32'd0;
   logic        flag_we = 1'b0;
   logic [2:0]  flags_in = 3'b000;
   logic        halt = 1'b0;
   logic [31:0] pc;
   logic [2:0]  flags;
   logic [31:0] retired;
   logic        halted;
   logic        fetch_err;

   int total = 0;
   int bad = 0;
   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_instr_q[$];
   logic        req_seen = 1'b0;

   always #5 clk = ~clk;

   pc_sequencer #(.RESET_PC(32'd0), .PC_STEP(32'd4), .FETCH_TMO(TMO)) dut (
      .clk(clk), .rst(rst), .run_en(run_en),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
      .ex_done(ex_done), .br_uncond(br_uncond), .br_cond(br_cond),
      .br_adsel(br_adsel), .br_addr(br_addr), .alu_res(alu_res),
      .flag_we(flag_we), .flags_in(flags_in), .halt(halt),
      .pc(pc), .flags(flags), .retired(retired), .halted(halted),
      .fetch_err(fetch_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Monitor: each new fetch and each instr_valid pulse consumes one expectation.
   always @(negedge clk) begin
      if (imem_req && !req_seen) begin
         if (exp_addr_q.size() == 0) chk("unexpected_fetch", imem_addr, 32'hxxxx_xxxx);
         else chk("fetch_addr", imem_addr, exp_addr_q.pop_front());
      end
      req_seen = imem_req;
      if (instr_valid) begin
         if (exp_instr_q.size() == 0) chk("unexpected_instr_valid", instr, 32'hxxxx_xxxx);
         else chk("instr", instr, exp_instr_q.pop_front());
      end
   end

   task automatic wait_req();
      int n = 0;
      while (!imem_req && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!imem_req) chk("req_wait_timeout", 32'(imem_req), 32'd1);
   endtask

   task automatic fetch(input logic [31:0] rdata, input int delay);
      wait_req();
      repeat (delay) begin
         @(posedge clk); #1;
      end
      exp_instr_q.push_back(rdata);
      imem_ack = 1'b1;
      imem_rdata = rdata;
      @(posedge clk); #1;
      imem_ack = 1'b0;
   endtask

   task automatic execute(input logic unc, input logic [2:0] cnd, input logic asel,
                          input logic [31:0] addr, input logic [31:0] alu,
                          input logic fwe, input logic [2:0] fin, input logic hlt,
                          input logic [31:0] exp_pc, input logic [2:0] exp_flags,
                          input logic [31:0] exp_ret);
      br_uncond = unc; br_cond = cnd; br_adsel = asel; br_addr = addr; alu_res = alu;
      flag_we = fwe; flags_in = fin; halt = hlt; ex_done = 1'b1;
      if (!hlt) exp_addr_q.push_back(exp_pc);
      @(posedge clk); #1;
      ex_done = 1'b0; br_uncond = 1'b0; br_cond = 3'b000; flag_we = 1'b0; halt = 1'b0;
      chk("pc", pc, exp_pc);
      chk("flags", 32'(flags), 32'(exp_flags));
      chk("retired", retired, exp_ret);
      chk("halted", 32'(halted), 32'(hlt));
   endtask

   task automatic chk_reset_vals();
      chk("rst_pc", pc, 32'd0);
      chk("rst_addr", imem_addr, 32'd0);
      chk("rst_flags", 32'(flags), 32'd0);
      chk("rst_retired", retired, 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_ivalid", 32'(instr_valid), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_ferr", 32'(fetch_err), 32'd0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals();
      rst = 1'b1;
      @(posedge clk); #1;
      chk("idle_no_req", 32'(imem_req), 32'd0);

      exp_addr_q.push_back(32'd0);
      run_en = 1'b1;
      fetch(32'h0000_00A5, 2);
      //        unc  cnd     sel  addr           alu    fwe  fin     hlt  pc             flags   ret
      execute(1'b1, 3'b000, 1'b0, 32'd2,         32'd0, 1'b0, 3'b000, 1'b0, 32'd2,        3'b000, 32'd1);
      fetch(32'h11, 0);
      execute(1'b0, 3'b000, 1'b0, 32'd77,        32'd0, 1'b0, 3'b000, 1'b0, 32'd6,        3'b000, 32'd2);
      fetch(32'h22, 1);
      execute(1'b1, 3'b000, 1'b0, 32'hFFFFFFFE,  32'd0, 1'b0, 3'b000, 1'b0, 32'hFFFFFFFE, 3'b000, 32'd3);
      fetch(32'h33, 0);
      execute(1'b0, 3'b000, 1'b0, 32'd0,         32'd0, 1'b0, 3'b000, 1'b0, 32'd2,        3'b000, 32'd4);
      fetch(32'h44, 0);
      execute(1'b0, 3'b000, 1'b0, 32'd0,         32'd0, 1'b1, 3'b001, 1'b0, 32'd6,        3'b001, 32'd5);
      fetch(32'h55, 3);
      execute(1'b0, 3'b001, 1'b0, 32'd35,        32'd0, 1'b0, 3'b000, 1'b0, 32'd35,       3'b001, 32'd6);
      fetch(32'h66, 0);
      execute(1'b0, 3'b000, 1'b0, 32'd0,         32'd0, 1'b1, 3'b010, 1'b0, 32'd39,       3'b010, 32'd7);
      fetch(32'h77, 0);
      execute(1'b0, 3'b001, 1'b0, 32'd35,        32'd0, 1'b0, 3'b000, 1'b0, 32'd43,       3'b010, 32'd8);
      fetch(32'h88, 0);
      execute(1'b0, 3'b000, 1'b0, 32'd0,         32'd0, 1'b1, 3'b000, 1'b0, 32'd47,       3'b000, 32'd9);
      fetch(32'h99, 0);
      execute(1'b0, 3'b001, 1'b0, 32'd99,        32'd0, 1'b1, 3'b001, 1'b0, 32'd51,       3'b001, 32'd10);
      fetch(32'hAA, 0);
      execute(1'b0, 3'b110, 1'b0, 32'd99,        32'd0, 1'b0, 3'b000, 1'b0, 32'd55,       3'b001, 32'd11);
      fetch(32'hBB, 0);
      execute(1'b0, 3'b111, 1'b0, 32'd200,       32'd0, 1'b0, 3'b000, 1'b0, 32'd200,      3'b001, 32'd12);
      fetch(32'hCC, 0);
      execute(1'b1, 3'b000, 1'b1, 32'd7,         32'd45, 1'b0, 3'b000, 1'b0, 32'd45,      3'b001, 32'd13);
      fetch(32'hDD, 1);
      execute(1'b0, 3'b000, 1'b0, 32'd0,         32'd0, 1'b0, 3'b000, 1'b1, 32'd49,       3'b001, 32'd14);

      imem_ack = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("halt_no_req", 32'(imem_req), 32'd0);
      end
      imem_ack = 1'b0;
      chk("halt_instr_kept", instr, 32'hDD);
      chk("halt_pc_kept", pc, 32'd49);
      chk("halt_no_ferr", 32'(fetch_err), 32'd0);

      rst = 1'b0;
      run_en = 1'b0;
      #1;
      chk_reset_vals();
      @(posedge clk); #1;
      rst = 1'b1;
      exp_addr_q.push_back(32'd0);
      run_en = 1'b1;
      wait_req();
      repeat (TMO - 1) @(posedge clk);
      #1;
      chk("tmo_still_req", 32'(imem_req), 32'd1);
      chk("tmo_not_yet", 32'(fetch_err), 32'd0);
      @(posedge clk); #1;
      chk("tmo_ferr", 32'(fetch_err), 32'd1);
      chk("tmo_halted", 32'(halted), 32'd1);
      chk("tmo_req_off", 32'(imem_req), 32'd0);
      chk("tmo_pc", pc, 32'd0);

      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      exp_addr_q.push_back(32'd0);
      wait_req();
      @(posedge clk); #3;
      rst = 1'b0;
      #1;
      chk_reset_vals();
      @(posedge clk); #1;

      chk("addr_q_drained", 32'(exp_addr_q.size()), 32'd0);
      chk("instr_q_drained", 32'(exp_instr_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1);
   end

endmodule
